imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader. It receives a framed byte stream over a valid/ready interface, assembles instruction words, and writes them into instruction memory through a single write port.
- It holds the processor core in reset (cpu_hold) until a complete frame passes its checksum.
- It sits beside the processor top level. It is the writer side of instruction memory; the core's fetch path is the reader.

Parameters:
- DATA_W, 16, instruction word width in bits. Must be a multiple of 8. BYTES = DATA_W/8 is derived internally.
- ADDR_W, 8, instruction memory address width. Capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins or restarts a load.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  DATA_W  write data.
- cpu_hold  out  1  1 = keep processor in reset.
- load_done  out  1  frame loaded and checksum good.
- load_error  out  1  frame rejected.
- words_loaded  out  ADDR_W+1  count of words written since the last start.

Behaviour:
- All outputs are registered.
- Reset values (async, while reset=0): rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_error=0, words_loaded=0, state=IDLE.
- Frame format:
  - header byte 0xA5
  - count byte N (number of words)
  - N*BYTES data bytes, MSB first within each word
  - checksum byte = sum of all data bytes mod 256
- A byte is accepted on a rising edge where rx_valid & rx_ready. Back-to-back bytes every cycle must be supported. rx_valid gaps stall the FSM without side effects.
- rx_ready=1 exactly in SYNC, COUNT, DATA and CSUM; 0 otherwise.
- States and transitions:
  - IDLE: start -> SYNC. Also clears words_loaded, the checksum accumulator, load_done and load_error.
  - SYNC: accepted byte != 0xA5 is discarded, stay in SYNC. 0xA5 -> COUNT.
  - COUNT: N==0 or N>2^ADDR_W -> ERR. Otherwise latch N, word index=0, byte index=0 -> DATA.
  - DATA: each accepted byte shifts into the assembly register and adds to the checksum. On the final byte of a word, the next cycle has imem_we=1, imem_addr=word index, imem_wdata=assembled word, and words_loaded increments. After the N-th word's final byte -> CSUM.
  - CSUM: accepted byte == accumulator -> DONE; otherwise -> ERR.
  - DONE: load_done=1, cpu_hold=0. start -> SYNC with cpu_hold=1, load_done=0, counters cleared (reload).
  - ERR: load_error=1, cpu_hold=1. start -> SYNC with load_error=0, counters cleared.
- Write latency: imem_we asserts exactly 1 cycle after acceptance of a word's last byte.
  - The last word's write may occur in the first CSUM cycle; this is legal.
  - imem_addr and imem_wdata hold their last values when imem_we=0.
- start is ignored in SYNC, COUNT, DATA and CSUM. It is sampled only in IDLE, DONE and ERR.
- cpu_hold deasserts only on the edge entering DONE. It is never 0 in any other state.
- Checksum arithmetic is 8-bit wrap-around. The count and checksum bytes are not included in the sum.
- Word index wraps only through the N bound. Addresses 0..N-1 are written in ascending order, each exactly once.
- Reset mid-frame returns immediately to reset values. Words already written remain in memory. A new start is required.
- A failed checksum does not undo completed writes. load_error alone marks memory contents invalid.

Test Plan:
- Good frame: reset, start, bytes A5 02 12 34 AB CD BE.
  - Required: imem_we pulses at addr 0 with data 0x1234, then addr 1 with 0xABCD.
  - Required: words_loaded=2, load_done=1, cpu_hold=0 one cycle after byte BE.
- Bad checksum: same frame ending BF.
  - Required: two writes occur, then load_error=1, cpu_hold=1, load_done=0.
- Sync hunt: start, bytes 00 FF 5A, then the good frame.
  - Required: the three leading bytes are discarded with no writes, and the result matches the good-frame case.
- Zero count: start, bytes A5 00.
  - Required: ERR, load_error=1, rx_ready=0, no imem_we.
  - Then start and the good frame: load_error clears and load completes.
- Stalls and reset mid-frame: good frame with rx_valid low 3 cycles between each byte.
  - Required: identical writes and result.
  - Repeat, asserting reset=0 after the first write: all outputs return to reset values; a subsequent start plus good frame succeeds.
- Reload: from DONE, pulse start.
  - Required: cpu_hold=1 on the next cycle, load_done=0, words_loaded=0.
  - Then send frame A5 01 00 07 07: a single write of 0x0007 at addr 0, then DONE.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input channel and instruction-memory write port
// of the boot loader, bundled so the loader and its neighbours share one
// definition.
//
// Signals:
//   rx_data    [7:0]         incoming byte
//   rx_valid                 rx_data holds a byte
//   rx_ready                 loader can take a byte this cycle
//   imem_we                  one-cycle write strobe per assembled word
//   imem_addr  [ADDR_W-1:0]  word address of the write
//   imem_wdata [DATA_W-1:0]  word being written
//
// Handshake: a byte moves on a rising clk edge where rx_valid and rx_ready are
// both 1. The source holds rx_data stable while rx_valid is 1 and not yet
// accepted. rx_ready does not depend on rx_valid, and a low rx_valid has no
// effect on the loader other than stalling it.
//
// Modports: slave = the loader, master = the byte source / memory side.
interface imem_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. It hunts for a 0xA5 header in the
// byte stream, reads a word count N, assembles N words (MSB byte first) and
// writes them to instruction memory at addresses 0..N-1. Then it compares a
// trailing 8-bit checksum (the sum of the data bytes). The core is held in
// reset (cpu_hold=1) until a frame passes its checksum.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   start         one-cycle pulse; starts a load from IDLE, DONE or ERR
//   bus           imem_loader_if.slave: rx byte channel + imem write port
//   cpu_hold      1 = keep the processor in reset
//   load_done     frame loaded and checksum good
//   load_error    frame rejected (bad count or bad checksum)
//   words_loaded  words written since the last start
//   state         current FSM state, exposed for debug and checkers
module imem_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        state
);
    localparam int BYTES = DATA_W / 8;
    localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W = ADDR_W + 1;
    localparam int CAP   = 2 ** ADDR_W;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SYNC  = 3'd1;
    localparam logic [2:0] COUNT = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] CSUM  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] ERR   = 3'd6;

    localparam logic [7:0] HEADER = 8'hA5;

    logic [2:0]        state_nxt;
    logic              accept;
    logic              last_byte;
    logic              last_word;
    logic              count_bad;
    logic              restart;
    logic [CNT_W-1:0]  count_n;
    logic [CNT_W-1:0]  word_idx;
    logic [BI_W-1:0]   byte_idx;
    logic [DATA_W-1:0] asm_reg;
    logic [DATA_W-1:0] asm_nxt;
    logic [7:0]        csum;

    assign accept    = bus.rx_valid & bus.rx_ready;
    assign asm_nxt   = (asm_reg << 8) | DATA_W'(bus.rx_data);
    assign last_byte = (byte_idx == BI_W'(BYTES - 1));
    assign last_word = (word_idx == count_n - CNT_W'(1));
    // A start accepted in IDLE, DONE or ERR begins a fresh frame hunt.
    assign restart   = (state_nxt == SYNC) &&
                       ((state == IDLE) || (state == DONE) || (state == ERR));

    // The count byte can only exceed capacity when the memory holds fewer
    // than 256 words. With wider addresses, zero is the only illegal count.
    if (ADDR_W >= 8) begin : g_cap_wide
        assign count_bad = (bus.rx_data == 8'd0);
    end else begin : g_cap_narrow
        assign count_bad = (bus.rx_data == 8'd0) || (bus.rx_data > 8'(CAP));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = SYNC;
            SYNC:  if (accept && (bus.rx_data == HEADER)) state_nxt = COUNT;
            COUNT: if (accept) state_nxt = count_bad ? ERR : DATA;
            DATA:  if (accept && last_byte && last_word) state_nxt = CSUM;
            CSUM:  if (accept) state_nxt = (bus.rx_data == csum) ? DONE : ERR;
            DONE:  if (start) state_nxt = SYNC;
            ERR:   if (start) state_nxt = SYNC;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_hold       <= 1'b1;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
            words_loaded   <= '0;
            count_n        <= '0;
            word_idx       <= '0;
            byte_idx       <= '0;
            asm_reg        <= '0;
            csum           <= '0;
        end else begin
            state        <= state_nxt;
            // Registered ready: it follows the state being entered, so it is
            // 1 exactly while the FSM sits in a byte-consuming state.
            bus.rx_ready <= (state_nxt == SYNC) || (state_nxt == COUNT) ||
                            (state_nxt == DATA) || (state_nxt == CSUM);
            bus.imem_we  <= 1'b0;

            if (restart) begin
                cpu_hold     <= 1'b1;
                load_done    <= 1'b0;
                load_error   <= 1'b0;
                words_loaded <= '0;
                csum         <= '0;
            end

            if ((state_nxt == DONE) && (state != DONE)) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
            end

            if ((state_nxt == ERR) && (state != ERR)) begin
                load_error <= 1'b1;
            end

            if ((state == COUNT) && accept && !count_bad) begin
                count_n  <= CNT_W'(bus.rx_data);
                word_idx <= '0;
                byte_idx <= '0;
            end

            if ((state == DATA) && accept) begin
                asm_reg <= asm_nxt;
                csum    <= csum + bus.rx_data;
                if (last_byte) begin
                    // The write lands one cycle after the word's last byte.
                    // For the final word, that cycle is the first CSUM cycle.
                    bus.imem_we    <= 1'b1;
                    bus.imem_addr  <= word_idx[ADDR_W-1:0];
                    bus.imem_wdata <= asm_nxt;
                    words_loaded   <= words_loaded + 1'b1;
                    word_idx       <= word_idx + 1'b1;
                    byte_idx       <= '0;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader. Frames are sent byte by byte
// through the valid/ready channel. A negedge monitor matches every imem write
// against an expected queue and checks that cpu_hold stays high outside DONE.
module tb_imem_loader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int W      = ADDR_W + DATA_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;
    logic [2:0]        state;

    int                checks   = 0;
    int                errors   = 0;
    int                wr_count = 0;
    int                w0;
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      exp_w;
    logic [7:0]        frame_q[$];

    imem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded),
        .state        (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.imem_we === 1'b1) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    check("spurious_write", 32'(bus.imem_we), 32'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("write_addr_data", 32'({bus.imem_addr, bus.imem_wdata}), 32'(exp_w));
                end
            end
            if (state !== S_DONE) check("cpu_hold_outside_done", 32'(cpu_hold), 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered and left on a negedge. rx_valid stays high so the next byte can
    // follow back-to-back.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_frame(input int gap);
        foreach (frame_q[i]) send_byte(frame_q[i], gap);
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_rx_ready"},   32'(bus.rx_ready),   32'd0);
        check({pfx, "_imem_we"},    32'(bus.imem_we),    32'd0);
        check({pfx, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
        check({pfx, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
        check({pfx, "_cpu_hold"},   32'(cpu_hold),       32'd1);
        check({pfx, "_load_done"},  32'(load_done),      32'd0);
        check({pfx, "_load_error"}, 32'(load_error),     32'd0);
        check({pfx, "_words"},      32'(words_loaded),   32'd0);
        check({pfx, "_state"},      32'(state),          32'(S_IDLE));
    endtask

    // Good frame A5 02 12 34 AB CD BE: checksum 12+34+AB+CD = 0x1BE -> 0xBE.
    task automatic run_good(input string pfx, input int gap, input logic hunt);
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h01, 16'hABCD});
        if (hunt) frame_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        else      frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        w0 = wr_count;
        send_frame(gap);
        check({pfx, "_writes"},     32'(wr_count - w0), 32'd2);
        check({pfx, "_exp_left"},   32'(exp_q.size()),  32'd0);
        check({pfx, "_load_done"},  32'(load_done),     32'd1);
        check({pfx, "_cpu_hold"},   32'(cpu_hold),      32'd0);
        check({pfx, "_words"},      32'(words_loaded),  32'd2);
        check({pfx, "_load_error"}, 32'(load_error),    32'd0);
        check({pfx, "_rx_ready"},   32'(bus.rx_ready),  32'd0);
        check({pfx, "_state"},      32'(state),         32'(S_DONE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start_state", 32'(state), 32'(S_IDLE));
        check("idle_rx_ready", 32'(bus.rx_ready), 32'd0);

        // Good frame
        pulse_start;
        check("start_state", 32'(state), 32'(S_SYNC));
        check("start_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("start_cpu_hold", 32'(cpu_hold), 32'd1);
        run_good("good", 0, 1'b0);

        // Bad checksum: writes happen, then ERR
        pulse_start;
        check("reload1_cpu_hold", 32'(cpu_hold), 32'd1);
        check("reload1_load_done", 32'(load_done), 32'd0);
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h01, 16'hABCD});
        frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF};
        w0 = wr_count;
        send_frame(0);
        check("badcs_writes", 32'(wr_count - w0), 32'd2);
        check("badcs_exp_left", 32'(exp_q.size()), 32'd0);
        check("badcs_load_error", 32'(load_error), 32'd1);
        check("badcs_cpu_hold", 32'(cpu_hold), 32'd1);
        check("badcs_load_done", 32'(load_done), 32'd0);
        check("badcs_words", 32'(words_loaded), 32'd2);
        check("badcs_state", 32'(state), 32'(S_ERR));
        check("badcs_rx_ready", 32'(bus.rx_ready), 32'd0);

        // Sync hunt: 00 FF 5A discarded
        pulse_start;
        check("hunt_err_cleared", 32'(load_error), 32'd0);
        run_good("hunt", 0, 1'b1);

        // Zero count
        pulse_start;
        frame_q = '{8'hA5, 8'h00};
        w0 = wr_count;
        send_frame(0);
        repeat (3) @(negedge clk);
        check("zero_state", 32'(state), 32'(S_ERR));
        check("zero_load_error", 32'(load_error), 32'd1);
        check("zero_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("zero_writes", 32'(wr_count - w0), 32'd0);
        check("zero_load_done", 32'(load_done), 32'd0);
        check("zero_words", 32'(words_loaded), 32'd0);
        pulse_start;
        check("zero_restart_err_cleared", 32'(load_error), 32'd0);
        run_good("after_zero", 0, 1'b0);

        // Stalls: 3 idle cycles before each byte
        pulse_start;
        run_good("stall", 3, 1'b0);

        // Reset mid-frame after the first write
        pulse_start;
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h01, 16'hABCD});
        frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34};
        w0 = wr_count;
        send_frame(3);
        @(negedge clk);
        check("midrst_first_write", 32'(wr_count - w0), 32'd1);
        check("midrst_exp_left", 32'(exp_q.size()), 32'd1);
        check("midrst_words_before", 32'(words_loaded), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_needs_start", 32'(state), 32'(S_IDLE));
        pulse_start;
        run_good("after_midrst", 0, 1'b0);

        // Reload from DONE with a one-word frame
        pulse_start;
        check("reload_cpu_hold", 32'(cpu_hold), 32'd1);
        check("reload_load_done", 32'(load_done), 32'd0);
        check("reload_words", 32'(words_loaded), 32'd0);
        check("reload_state", 32'(state), 32'(S_SYNC));
        exp_q.push_back({8'h00, 16'h0007});
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h07, 8'h07};
        w0 = wr_count;
        send_frame(0);
        check("reload_writes", 32'(wr_count - w0), 32'd1);
        check("reload_exp_left", 32'(exp_q.size()), 32'd0);
        check("reload_done", 32'(load_done), 32'd1);
        check("reload_hold_released", 32'(cpu_hold), 32'd0);
        check("reload_words_after", 32'(words_loaded), 32'd1);
        check("reload_state_after", 32'(state), 32'(S_DONE));

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
